regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
Owns the single write port (we/wa/wd) of regfile_32bit and shares it between two writeback requesters using a valid/ready handshake with round-robin priority. After reset it runs a zero-fill sequence that clears every register before accepting any requester traffic. All outputs to the register file are registered, so a granted write reaches the regfile one cycle after acceptance.

Parameters:
RWIDTH, 6, register address width; the register file has 2**RWIDTH entries.
DWIDTH, 32, data width.
ZERO_PROTECT, 0, when 1 a write to address 0 is accepted but suppressed (we stays 0).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
req0_valid  in  1  requester 0 has a write pending.
req0_addr  in  RWIDTH  requester 0 destination register.
req0_data  in  DWIDTH  requester 0 write data.
req0_ready  out  1  requester 0 accepted this cycle.
req1_valid  in  1  requester 1 has a write pending.
req1_addr  in  RWIDTH  requester 1 destination register.
req1_data  in  DWIDTH  requester 1 write data.
req1_ready  out  1  requester 1 accepted this cycle.
we  out  1  regfile write enable (registered).
wa  out  RWIDTH  regfile write address (registered).
wd  out  DWIDTH  regfile write data (registered).
init_done  out  1  high once the zero-fill is complete.
last_grant  out  1  index of the most recently accepted requester.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=INIT, fill counter=0, round-robin pointer=0 (requester 0 preferred).
  - we=0, wa=0, wd=0, init_done=0, last_grant=0; req0_ready and req1_ready = 0.
- INIT:
  - On each rising edge: we<=1, wa<=counter, wd<=0, then counter increments.
  - After the edge that drives wa=2**RWIDTH-1, the next edge moves state to RUN, with we<=0 and init_done<=1.
  - Both readies are 0 throughout INIT regardless of valid.
  - Total: exactly 2**RWIDTH consecutive cycles with we=1.
- RUN: arbitration is combinational within the cycle.
  - Only reqN_valid high: grant N.
  - Both valid: grant the requester named by the pointer.
  - Neither valid: no grant.
- reqN_ready = (state==RUN) && grantN. A transfer occurs on an edge where valid && ready.
- On a transfer from requester N:
  - Next edge: we<=1, wa<=reqN_addr, wd<=reqN_data, last_grant<=N.
  - Pointer <= the other requester (1-N).
  - Latency from accept to we=1 is one cycle.
- With no transfer: we<=0; wa, wd and last_grant hold their values; the pointer holds.
- ZERO_PROTECT=1 and the granted address is 0: the handshake completes (ready=1), the pointer advances and last_grant updates, but we<=0 and wa/wd hold.
- Requester contract: once valid is high, addr/data stay stable until ready. A requester may deassert only after its transfer. The arbiter does not check this.
- Both requesters targeting the same address: only the grantee is written that cycle. The loser stays pending and is written the following cycle, so the last writer wins. No merging.
- Throughput: one write per cycle sustained. Under continuous dual requests, grants alternate strictly.
- Reset mid-INIT or mid-RUN:
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - Any write registered but not yet committed is dropped.
  - After rst_n rises, zero-fill restarts at wa=0.
- There is no read path. ra1/ra2 connect directly to the regfile. Software must not rely on register contents before init_done=1.

Test Plan:
1. Release rst_n, both valid held high with addr 5 -> we=1 for 64 consecutive cycles, wa=0..63, wd=0; readies stay 0; init_done=1 on the cycle after wa=63; read of ra1=35 returns 0.
2. After init, req0 valid with addr 12, data AAAAAAAA, one cycle -> req0_ready=1 that cycle; next cycle we=1, wa=12, wd=AAAAAAAA, last_grant=0; following cycle we=0; rd1 at ra1=12 reads AAAAAAAA.
3. Both valid continuously, req0 (addr 63, FFAAFFAA) and req1 (addr 12, 11111111), from the first RUN cycle -> grants alternate 0,1,0,1; wa sequence 63,12,63,12 with matching wd; we stays high.
4. Both valid for addr 7, req0 data 00000001, req1 data 00000002, with pointer=1 -> req1 written first, then req0; regfile entry 7 ends at 00000001.
5. req1 writes addr 0, data BBBBBBBB: with ZERO_PROTECT=0 -> we=1, wa=0; with ZERO_PROTECT=1 -> req1_ready=1, we=0, pointer advances to 0, entry 0 still reads 00000000.
6. Assert rst_n low between edges during a dual-request burst -> we, readies and init_done drop to 0 before the next edge; after release the zero-fill restarts at wa=0 and entries 12 and 63 read 0 after init_done.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Sole owner of the regfile write port: zero-fills every entry after reset, then
// round-robin arbitrates two valid/ready writeback requesters onto registered we/wa/wd.
module regfile_wr_arbiter #(
  parameter int RWIDTH       = 6,
  parameter int DWIDTH       = 32,
  parameter int ZERO_PROTECT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [RWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [RWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_data,
  output logic              req1_ready,
  output logic              we,
  output logic [RWIDTH-1:0] wa,
  output logic [DWIDTH-1:0] wd,
  output logic              init_done,
  output logic              last_grant
);

  // The fill counter carries one extra bit so the terminal count marks "all entries written".
  localparam logic [RWIDTH:0] FILL_END = {1'b1, {RWIDTH{1'b0}}};

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_reg, state_next;
  logic [RWIDTH:0]   fill_cnt_reg, fill_cnt_next;
  logic              ptr_reg, ptr_next;
  logic              we_reg, we_next;
  logic [RWIDTH-1:0] wa_reg, wa_next;
  logic [DWIDTH-1:0] wd_reg, wd_next;
  logic              init_done_reg, init_done_next;
  logic              last_grant_reg, last_grant_next;
  logic              grant0, grant1;
  logic [RWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_data;

  always_comb begin
    state_next      = state_reg;
    fill_cnt_next   = fill_cnt_reg;
    ptr_next        = ptr_reg;
    we_next         = 1'b0;
    wa_next         = wa_reg;
    wd_next         = wd_reg;
    init_done_next  = init_done_reg;
    last_grant_next = last_grant_reg;
    grant0          = 1'b0;
    grant1          = 1'b0;
    sel_addr        = req0_addr;
    sel_data        = req0_data;

    case (state_reg)
      ST_INIT: begin
        if (fill_cnt_reg == FILL_END) begin
          state_next     = ST_RUN;
          init_done_next = 1'b1;
        end else begin
          we_next       = 1'b1;
          wa_next       = fill_cnt_reg[RWIDTH-1:0];
          wd_next       = '0;
          fill_cnt_next = fill_cnt_reg + 1'b1;
        end
      end
      ST_RUN: begin
        // Pointer only breaks ties; a lone requester always wins.
        grant0 = req0_valid && (!req1_valid || !ptr_reg);
        grant1 = req1_valid && (!req0_valid ||  ptr_reg);
        if (grant1) begin
          sel_addr = req1_addr;
          sel_data = req1_data;
        end
        if (grant0 || grant1) begin
          last_grant_next = grant1;
          ptr_next        = !grant1;
          if (!((ZERO_PROTECT != 0) && (sel_addr == '0))) begin
            we_next = 1'b1;
            wa_next = sel_addr;
            wd_next = sel_data;
          end
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_INIT;
      fill_cnt_reg   <= '0;
      ptr_reg        <= 1'b0;
      we_reg         <= 1'b0;
      wa_reg         <= '0;
      wd_reg         <= '0;
      init_done_reg  <= 1'b0;
      last_grant_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fill_cnt_reg   <= fill_cnt_next;
      ptr_reg        <= ptr_next;
      we_reg         <= we_next;
      wa_reg         <= wa_next;
      wd_reg         <= wd_next;
      init_done_reg  <= init_done_next;
      last_grant_reg <= last_grant_next;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign we         = we_reg;
  assign wa         = wa_reg;
  assign wd         = wd_reg;
  assign init_done  = init_done_reg;
  assign last_grant = last_grant_reg;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Drives two arbiters (zero-protect off and on) with shared requesters and checks them
// against a transaction-level model of the fill sequence, round-robin order and regfile contents.
module tb_regfile_wr_arbiter;

  localparam int RW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          v0, v1;
  logic [RW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;

  logic          rdy0_a, rdy1_a, we_a, done_a, lg_a;
  logic [RW-1:0] wa_a;
  logic [DW-1:0] wd_a;
  logic          rdy0_b, rdy1_b, we_b, done_b, lg_b;
  logic [RW-1:0] wa_b;
  logic [DW-1:0] wd_b;

  int compared   = 0;
  int mismatched = 0;

  // Regfiles fed by each DUT, and the contents the model says they must hold.
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [DW-1:0] ref_a [DEPTH];
  logic [DW-1:0] ref_b [DEPTH];

  // Model: edges seen since reset release, preferred requester, expected port values.
  int            edges;
  int            pref;
  logic          e_we_a, e_we_b, e_last;
  logic [RW-1:0] e_wa_a, e_wa_b;
  logic [DW-1:0] e_wd_a, e_wd_b;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.RWIDTH(RW), .DWIDTH(DW), .ZERO_PROTECT(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(rdy0_a),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(rdy1_a),
    .we(we_a), .wa(wa_a), .wd(wd_a), .init_done(done_a), .last_grant(lg_a)
  );

  regfile_wr_arbiter #(.RWIDTH(RW), .DWIDTH(DW), .ZERO_PROTECT(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(rdy0_b),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(rdy1_b),
    .we(we_b), .wa(wa_b), .wd(wd_b), .init_done(done_b), .last_grant(lg_b)
  );

  always @(posedge clk) begin
    if (we_a) mem_a[wa_a] <= wd_a;
    if (we_b) mem_b[wa_b] <= wd_b;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    edges  = 0;
    pref   = 0;
    e_we_a = 1'b0; e_wa_a = '0; e_wd_a = '0;
    e_we_b = 1'b0; e_wa_b = '0; e_wd_b = '0;
    e_last = 1'b0;
  endtask

  task automatic chk_reset_values();
    chk("rst_we_a", we_a, 0);     chk("rst_we_b", we_b, 0);
    chk("rst_wa_a", wa_a, 0);     chk("rst_wd_a", wd_a, 0);
    chk("rst_done_a", done_a, 0); chk("rst_done_b", done_b, 0);
    chk("rst_lg_a", lg_a, 0);     chk("rst_lg_b", lg_b, 0);
    chk("rst_rdy0", rdy0_a, 0);   chk("rst_rdy1", rdy1_a, 0);
    chk("rst_rdy0_b", rdy0_b, 0); chk("rst_rdy1_b", rdy1_b, 0);
  endtask

  // Called at a negedge: check, step the model across the next posedge, return at next negedge.
  task automatic cycle();
    int            g;
    bit            running;
    logic [RW-1:0] addr;
    logic [DW-1:0] data;
    #1;
    running = (edges > DEPTH);
    g = -1;
    if (running) begin
      if (v0 && v1) g = pref;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    chk("ready0_a", rdy0_a, g == 0); chk("ready1_a", rdy1_a, g == 1);
    chk("ready0_b", rdy0_b, g == 0); chk("ready1_b", rdy1_b, g == 1);
    chk("init_done_a", done_a, running); chk("init_done_b", done_b, running);
    chk("we_a", we_a, e_we_a); chk("wa_a", wa_a, e_wa_a); chk("wd_a", wd_a, e_wd_a);
    chk("we_b", we_b, e_we_b); chk("wa_b", wa_b, e_wa_b); chk("wd_b", wd_b, e_wd_b);
    chk("last_grant_a", lg_a, e_last); chk("last_grant_b", lg_b, e_last);

    @(posedge clk);
    if (e_we_a) ref_a[e_wa_a] = e_wd_a;
    if (e_we_b) ref_b[e_wa_b] = e_wd_b;
    e_we_a = 1'b0;
    e_we_b = 1'b0;
    if (edges < DEPTH) begin
      e_we_a = 1'b1; e_wa_a = RW'(edges); e_wd_a = '0;
      e_we_b = 1'b1; e_wa_b = RW'(edges); e_wd_b = '0;
    end else if (g >= 0) begin
      addr   = (g == 1) ? a1 : a0;
      data   = (g == 1) ? d1 : d0;
      e_last = (g == 1);
      pref   = 1 - g;
      e_we_a = 1'b1; e_wa_a = addr; e_wd_a = data;
      if (addr != 0) begin
        e_we_b = 1'b1; e_wa_b = addr; e_wd_b = data;
      end
    end
    edges++;
    #1;
    if (g == 0) v0 = 1'b0;
    if (g == 1) v1 = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [RW-1:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return RW'(0);
      1:       return RW'(7);
      2:       return RW'(12);
      3:       return RW'(63);
      default: return RW'($urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  initial begin
    model_reset();
    rst_n = 1'b0;
    v0 = 1'b1; a0 = RW'(5); d0 = 32'h5555_0000;
    v1 = 1'b1; a1 = RW'(5); d1 = 32'h5555_0001;
    #12;
    chk_reset_values();

    // Zero-fill with both requesters already waiting, then they drain in order 0,1.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DEPTH + 1) cycle();
    chk("fill_ra35", mem_a[35], 0);
    repeat (3) cycle();
    chk("addr5_last_writer", mem_a[5], 32'h5555_0001);

    // Single request from requester 0.
    v0 = 1'b1; a0 = RW'(12); d0 = 32'hAAAA_AAAA;
    repeat (3) cycle();
    chk("rd_ra12", mem_a[12], 32'hAAAA_AAAA);

    // Continuous dual requests alternate strictly.
    v0 = 1'b1; a0 = RW'(63); d0 = 32'hFFAA_FFAA;
    v1 = 1'b1; a1 = RW'(12); d1 = 32'h1111_1111;
    repeat (6) begin
      cycle();
      v0 = 1'b1;
      v1 = 1'b1;
    end
    repeat (3) cycle();

    // Same address from both with pointer on requester 1: requester 0 lands last.
    if (pref != 1) begin
      v0 = 1'b1; a0 = RW'(20); d0 = 32'h2020_2020;
      repeat (2) cycle();
    end
    v0 = 1'b1; a0 = RW'(7); d0 = 32'h0000_0001;
    v1 = 1'b1; a1 = RW'(7); d1 = 32'h0000_0002;
    repeat (4) cycle();
    chk("same_addr_a", mem_a[7], 32'h0000_0001);

    // Address 0 write: committed without protection, suppressed with it.
    v1 = 1'b1; a1 = RW'(0); d1 = 32'hBBBB_BBBB;
    repeat (3) cycle();
    chk("zero_write_a", mem_a[0], 32'hBBBB_BBBB);
    chk("zero_protect_b", mem_b[0], 0);

    // Random traffic respecting the hold-until-ready contract.
    repeat (400) begin
      if (!v0 && $urandom_range(0, 2) != 0) begin
        v0 = 1'b1; a0 = pick_addr(); d0 = $urandom;
      end
      if (!v1 && $urandom_range(0, 2) != 0) begin
        v1 = 1'b1; a1 = pick_addr(); d1 = $urandom;
      end
      cycle();
    end
    repeat (4) cycle();
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("mem_a[%0d]", i), mem_a[i], ref_a[i]);
      chk($sformatf("mem_b[%0d]", i), mem_b[i], ref_b[i]);
    end

    // Asynchronous reset in the middle of a dual-request burst.
    v0 = 1'b1; a0 = RW'(63); d0 = 32'hDEAD_0063;
    v1 = 1'b1; a1 = RW'(12); d1 = 32'hDEAD_0012;
    repeat (3) begin
      cycle();
      v0 = 1'b1;
      v1 = 1'b1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values();
    model_reset();
    v0 = 1'b0;
    v1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DEPTH + 2) cycle();
    chk("refill_ra12_a", mem_a[12], 0);
    chk("refill_ra63_a", mem_a[63], 0);
    chk("refill_ra12_b", mem_b[12], 0);
    chk("refill_ra63_b", mem_b[63], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
